// File: rtl/ahb_slv_pkg.sv
// ahb_slv_pkg: shared FSM state encoding, HRESP codes and counter sizing for the AHB-Lite slave memory
package ahb_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        XFER,
        ERR1,
        ERR2
    } state_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // The wait counter only ever holds WAIT_CYCLES-1, so it needs just enough bits for that value.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 2) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/ahb_slv_ram.sv
// ahb_slv_ram: DEPTH x 32 word RAM, one synchronous write port, one asynchronous read port
//   HCLK    - write clock
//   we      - write enable
//   wr_addr - write word index
//   wr_data - write data
//   rd_addr - read word index
//   rd_data - combinational read data
module ahb_slv_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge HCLK)
        if (we) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem: AHB-Lite slave with word-addressed RAM and programmable data-phase wait states
//   HCLK   - bus clock
//   HRESET - asynchronous active-high reset
//   HSEL   - slave select (address phase)
//   HADDR  - byte address (address phase)
//   HWRITE - 1 = write, 0 = read (address phase)
//   HWDATA - write data (data phase)
//   HRDATA - read data, valid in the final read data-phase cycle, 0 otherwise
//   HRESP  - 0 = OKAY, 1 = ERROR; exists only when AHB_SLV_ERR_RESP_EN is defined
//   HREADY - data phase done / ready for the next address phase
// Optional feature macro: AHB_SLV_ERR_RESP_EN (out-of-range accesses get a two-cycle ERROR response).
module ahb_lite_slave_mem
    import ahb_slv_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
`ifdef AHB_SLV_ERR_RESP_EN
    output logic        HRESP,
`endif
    output logic        HREADY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(WAIT_CYCLES);

    state_t        state_q, state_d, start_state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic          wr_q, hit_q;
    logic          accept, hit_d, we;
    logic [31:0]   rd_data;
    logic          unused_addr;

    // Byte-lane bits carry no meaning for a word-only memory.
    assign unused_addr = ^HADDR[1:0];

    assign hit_d  = HADDR[31:2+AW] == BASE_ADDR[31:2+AW];
    assign accept = HSEL && HREADY;
    assign HREADY = !(state_q == WAIT || state_q == ERR1);
    // Writes commit on the edge that closes the data phase, so a following read sees them without forwarding.
    assign we     = state_q == XFER && wr_q && hit_q;
    assign HRDATA = (state_q == XFER && !wr_q && hit_q) ? rd_data : '0;

`ifdef AHB_SLV_ERR_RESP_EN
    assign HRESP       = (state_q == ERR1 || state_q == ERR2) ? RESP_ERROR : RESP_OKAY;
    assign start_state = !hit_d ? ERR1 : (WAIT_CYCLES > 0) ? WAIT : XFER;
`else
    assign start_state = (WAIT_CYCLES > 0) ? WAIT : XFER;
`endif

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q <= HADDR[2+AW-1:2];
                wr_q  <= HWRITE;
                hit_q <= hit_d;
            end
        end

    // Every HREADY-high state (IDLE, XFER, ERR2) either takes a new transfer or drops to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == WAIT) begin
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
            state_d = (cnt_q == '0) ? XFER : WAIT;
        end else if (state_q == ERR1)
            state_d = ERR2;
        else if (accept) begin
            state_d = start_state;
            cnt_d   = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
        end else
            state_d = IDLE;
    end

    ahb_slv_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .HCLK    (HCLK),
        .we      (we),
        .wr_addr (idx_q),
        .wr_data (HWDATA),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

endmodule
